rca_mul_seq: RTL and testbench



---
 rtl/rca_mul_seq_if.sv | 27 ++
 rtl/rca_mul_seq.sv | 100 ++++++++++
 tb/tb_rca_mul_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rca_mul_seq_if.sv
// Request/result handshake and shared-adder port bundle for rca_mul_seq.
// slave = the sequencer; master = requester plus the external ripple-carry adder.
interface rca_mul_seq_if #(parameter int N = 32);
  logic           req_valid;
  logic           req_ready;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           abort;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic [2*N-1:0] res_product;
  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  modport slave (
    input  req_valid, op_a, op_b, abort, res_ready, add_sum, add_cout,
    output req_ready, busy, res_valid, res_product, add_a, add_b
  );

  modport master (
    output req_valid, op_a, op_b, abort, res_ready, add_sum, add_cout,
    input  req_ready, busy, res_valid, res_product, add_a, add_b
  );
endinterface

// File: rtl/rca_mul_seq.sv
// Unsigned N x N -> 2N shift-and-add multiplier driving one shared external N-bit adder.
// Optional MUL_EARLY_EXIT_EN: a zero operand skips the iterations and goes straight to DONE.
module rca_mul_seq #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  rca_mul_seq_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [N-1:0]    mcand;
  logic [N-1:0]    acc_hi;
  logic [N-1:0]    acc_lo;
  logic [CW-1:0]   cnt;
  logic            req_ready_q;
  logic            busy_q;
  logic            res_valid_q;
  logic            early;

`ifdef MUL_EARLY_EXIT_EN
  assign early = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mcand       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            mcand       <= bus.op_a;
            cnt         <= '0;
            req_ready_q <= 1'b0;
            if (early) begin
              acc_hi      <= '0;
              acc_lo      <= '0;
              state       <= DONE;
              res_valid_q <= 1'b1;
            end else begin
              acc_hi <= '0;
              acc_lo <= bus.op_b;
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end else begin
            // carry-out lands in the top bit, so the 2N-bit shift never loses a bit
            {acc_hi, acc_lo} <= {bus.add_cout, bus.add_sum, acc_lo[N-1:1]};
            cnt              <= cnt + 1'b1;
            if (cnt == CW'(N-1)) begin
              state       <= DONE;
              busy_q      <= 1'b0;
              res_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Adder operands are gated to zero outside RUN to keep the shared adder quiet.
  assign bus.add_a       = busy_q ? acc_hi : '0;
  assign bus.add_b       = (busy_q && acc_lo[0]) ? mcand : '0;
  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = {acc_hi, acc_lo};
endmodule

// File: tb/tb_rca_mul_seq.sv
// Randomized self-checking bench for rca_mul_seq; models the external adder and
// checks products against plain 64-bit multiplication.
module tb_rca_mul_seq;
  localparam int N = 32;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  rca_mul_seq_if #(.N(N)) bus();

  // external ripple-carry adder, carry-in 0
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  rca_mul_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and take the accept edge (E0).
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!bus.req_ready && w < 100) begin
      tick();
      w++;
    end
    chk("req_ready_before_start", 64'(bus.req_ready), 64'd1);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Edges after E0 until res_valid; also flags any non-zero add_b when b is zero.
  task automatic wait_done(input logic [31:0] b, output int cyc, output bit addb_bad);
    cyc = 0;
    addb_bad = 1'b0;
    while (!bus.res_valid && cyc < 200) begin
      if (b == 0 && bus.add_b != 0) addb_bad = 1'b1;
      tick();
      cyc++;
    end
  endtask

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    if (a == 0 || b == 0) return 0;
`endif
    return N;
  endfunction

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    int cyc;
    bit addb_bad;
    logic [63:0] exp;
    exp = 64'(a) * 64'(b);
    start(a, b);
    chk("busy_after_accept", 64'(bus.busy), (exp_latency(a, b) == N) ? 64'd1 : 64'd0);
    wait_done(b, cyc, addb_bad);
    chk("latency", 64'(cyc), 64'(exp_latency(a, b)));
    chk("product", bus.res_product, exp);
    if (b == 0) chk("add_b_zero", 64'(addb_bad), 64'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("req_ready_after_consume", 64'(bus.req_ready), 64'd1);
    chk("adder_idle", {bus.add_a, bus.add_b}, 64'd0);
  endtask

  initial begin
    int cyc;
    bit bad;
    logic [31:0] ra, rb;
    bus.req_valid = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.abort     = 1'b0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_product", bus.res_product, 64'd0);
    chk("rst_adder", {bus.add_a, bus.add_b}, 64'd0);

    run_mul(32'd3, 32'd5);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // result stall: extra requests must be ignored while DONE waits
    start(32'd7, 32'd9);
    wait_done(32'd9, cyc, bad);
    chk("stall_latency", 64'(cyc), 64'(N));
    bus.op_a = 32'd11;
    bus.op_b = 32'd13;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_res_valid", 64'(bus.res_valid), 64'd1);
      chk("stall_product", bus.res_product, 64'd63);
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("stall_released", 64'(bus.req_ready), 64'd1);
    chk("stall_product_kept", bus.res_product, 64'd63);

    // abort during iteration 10
    start(32'h1234, 32'h5678);
    repeat (10) begin
      chk("abort_no_valid_run", 64'(bus.res_valid), 64'd0);
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (3) begin
      chk("abort_no_valid", 64'(bus.res_valid), 64'd0);
      tick();
    end
    run_mul(32'd7, 32'd6);

    // abort in DONE is ignored; abort with res_ready is a normal consume
    start(32'd5, 32'd9);
    wait_done(32'd9, cyc, bad);
    bus.abort = 1'b1;
    tick();
    chk("done_abort_valid", 64'(bus.res_valid), 64'd1);
    chk("done_abort_product", bus.res_product, 64'd45);
    bus.res_ready = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.res_ready = 1'b0;
    chk("done_abort_consume", 64'(bus.req_ready), 64'd1);

    // abort in IDLE is ignored
    bus.abort = 1'b1;
    start(32'd12, 32'd12);
    bus.abort = 1'b0;
    chk("idle_abort_busy", 64'(bus.busy), 64'd1);
    wait_done(32'd12, cyc, bad);
    chk("idle_abort_product", bus.res_product, 64'd144);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // reset mid-run
    start(32'd9, 32'd9);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("mid_rst_product", bus.res_product, 64'd0);

    run_mul(32'd0, 32'h1357_9BDF);
    run_mul(32'hDEAD_BEEF, 32'd0);

    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'd0;
        1: rb = 32'd0;
        2: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_mul(ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
